// File: rtl/nxm_rr_arb.sv
// nxm_rr_arb: shares NUM_RES identical resources among NUM_REQ requesters.
// Up to NUM_RES grants are active at once, each tagged with a resource index.
// Allocation order is round-robin (mode=0) or fixed priority, index 0 first (mode=1).
// Optional feature macro: HOLD_TIMEOUT_EN revokes any grant held for MAX_HOLD cycles.
module nxm_rr_arb #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_RES  = 2,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned RES_W   = (NUM_RES > 1) ? $clog2(NUM_RES) : 1,
    localparam int unsigned REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       rel,
    input  logic                     mode,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ*RES_W-1:0] grant_res,
    output logic [NUM_RES-1:0]       res_busy,
    output logic [NUM_REQ-1:0]       timeout
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } req_state_e;

    req_state_e                    state_q [NUM_REQ];
    req_state_e                    state_d [NUM_REQ];
    logic [NUM_REQ-1:0][RES_W-1:0] res_q;
    logic [NUM_REQ-1:0][RES_W-1:0] res_d;
    logic [NUM_RES-1:0]            busy_q;
    logic [NUM_RES-1:0]            busy_d;
    logic [REQ_W-1:0]              ptr_q;
    logic [REQ_W-1:0]              ptr_d;

    logic [NUM_REQ-1:0]            held;
    logic [NUM_REQ-1:0]            expire;
    logic [NUM_REQ-1:0]            skip;

    logic [NUM_RES-1:0]            avail;
    logic                          found;
    logic                          any_grant;
    logic [REQ_W-1:0]              last_idx;
    logic [REQ_W-1:0]              idx;
    logic [REQ_W:0]                rot;

    // Per-requester state, owner tables and round-robin pointer
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                state_q[i] <= ST_IDLE;
            end
            res_q  <= '0;
            busy_q <= '0;
            ptr_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                state_q[i] <= state_d[i];
            end
            res_q  <= res_d;
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
        end
    end

    // Decode granted requesters from the state flops
    always_comb begin
        held = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            held[i] = (state_q[i] == ST_GRANTED);
        end
    end

    // Release phase then allocation phase; freed resources only become free next cycle
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            state_d[i] = state_q[i];
        end
        res_d     = res_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        avail     = ~busy_q;
        found     = 1'b0;
        any_grant = 1'b0;
        last_idx  = '0;
        idx       = '0;
        rot       = '0;

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (state_q[i] == ST_GRANTED && (rel[i] || !req[i] || expire[i])) begin
                state_d[i] = ST_IDLE;
                res_d[i]   = '0;
                for (int r = 0; r < int'(NUM_RES); r++) begin
                    if (res_q[i] == RES_W'(r)) begin
                        busy_d[r] = 1'b0;
                    end
                end
            end
        end

        for (int k = 0; k < int'(NUM_REQ); k++) begin
            rot = {1'b0, ptr_q} + (REQ_W+1)'(k);
            if (rot >= (REQ_W+1)'(NUM_REQ)) begin
                rot = rot - (REQ_W+1)'(NUM_REQ);
            end
            idx = mode ? REQ_W'(k) : REQ_W'(rot);
            if (state_q[idx] == ST_IDLE && req[idx] && !skip[idx]) begin
                found = 1'b0;
                for (int r = 0; r < int'(NUM_RES); r++) begin
                    if (!found && avail[r]) begin
                        found      = 1'b1;
                        avail[r]   = 1'b0;
                        busy_d[r]  = 1'b1;
                        res_d[idx] = RES_W'(r);
                    end
                end
                if (found) begin
                    state_d[idx] = ST_GRANTED;
                    any_grant    = 1'b1;
                    last_idx     = idx;
                end
            end
        end

        if (any_grant && !mode) begin
            if (last_idx == REQ_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = last_idx + REQ_W'(1);
            end
        end
    end

`ifdef HOLD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_REQ-1:0]            tout_q;

    // Hold age per requester (0 on the first granted cycle) and revoke pulse
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q  <= '0;
            tout_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!held[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != CNT_W'(MAX_HOLD)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            tout_q <= expire & req & ~rel;
        end
    end

    // Grant expires once its age reaches the limit
    always_comb begin
        expire = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            expire[i] = held[i] && (cnt_q[i] == CNT_W'(MAX_HOLD));
        end
    end

    assign skip    = tout_q;
    assign timeout = tout_q;
`else
    assign expire  = '0;
    assign skip    = '0;
    assign timeout = '0;
`endif

    assign grant     = held;
    assign grant_res = res_q;
    assign res_busy  = busy_q;

endmodule

// File: tb/tb_nxm_rr_arb.sv
// tb_nxm_rr_arb: directed scenarios plus randomized traffic checked against a
// queue-based allocation model. Timeout scenario built when HOLD_TIMEOUT_EN is defined.
module tb_nxm_rr_arb;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned NUM_RES  = 2;
    localparam int unsigned MAX_HOLD = 16;
    localparam int unsigned RES_W    = 1;

    logic                     ACLK;
    logic                     ARESETN;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       rel;
    logic                     mode;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ*RES_W-1:0] grant_res;
    logic [NUM_RES-1:0]       res_busy;
    logic [NUM_REQ-1:0]       timeout;

    int checks;
    int errors;
    int cyc;

    // Model: resource held by each requester (-1 idle), owner of each resource (-1 free)
    int m_hold [NUM_REQ];
    int m_own  [NUM_RES];
    int m_age  [NUM_REQ];
    bit m_tout [NUM_REQ];
    int m_ptr;

    logic [NUM_REQ-1:0]       e_grant;
    logic [NUM_REQ*RES_W-1:0] e_gres;
    logic [NUM_RES-1:0]       e_busy;
    logic [NUM_REQ-1:0]       e_tout;

    nxm_rr_arb #(
        .NUM_REQ  (NUM_REQ),
        .NUM_RES  (NUM_RES),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req       (req),
        .rel       (rel),
        .mode      (mode),
        .grant     (grant),
        .grant_res (grant_res),
        .res_busy  (res_busy),
        .timeout   (timeout)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic model_outputs();
        e_grant = '0;
        e_gres  = '0;
        e_busy  = '0;
        e_tout  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (m_hold[i] >= 0) begin
                e_grant[i] = 1'b1;
                e_gres[i*RES_W +: RES_W] = RES_W'(m_hold[i]);
            end
            e_tout[i] = m_tout[i];
        end
        for (int r = 0; r < int'(NUM_RES); r++) begin
            e_busy[r] = (m_own[r] >= 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            m_hold[i] = -1;
            m_age[i]  = 0;
            m_tout[i] = 1'b0;
        end
        for (int r = 0; r < int'(NUM_RES); r++) begin
            m_own[r] = -1;
        end
        m_ptr = 0;
        model_outputs();
    endtask

    // One clock edge of the arbitration rules, using the currently driven inputs
    task automatic model_step();
        int nh [NUM_REQ];
        int no [NUM_RES];
        bit nt [NUM_REQ];
        int cq [$];
        int fq [$];
        int n;
        int idx;
        bit gone;
        bit expd;
        nh = m_hold;
        no = m_own;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            nt[i] = 1'b0;
            if (m_hold[i] >= 0) begin
                gone = rel[i] || !req[i];
                expd = 1'b0;
`ifdef HOLD_TIMEOUT_EN
                expd = (m_age[i] == int'(MAX_HOLD));
`endif
                if (gone || expd) begin
                    no[m_hold[i]] = -1;
                    nh[i] = -1;
                    nt[i] = expd && !gone;
                end else begin
                    m_age[i] = m_age[i] + 1;
                end
            end
        end
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = mode ? k : (m_ptr + k) % int'(NUM_REQ);
            if (m_hold[idx] < 0 && req[idx] && !m_tout[idx]) cq.push_back(idx);
        end
        for (int r = 0; r < int'(NUM_RES); r++) begin
            if (m_own[r] < 0) fq.push_back(r);
        end
        n = (cq.size() < fq.size()) ? cq.size() : fq.size();
        for (int j = 0; j < n; j++) begin
            nh[cq[j]] = fq[j];
            no[fq[j]] = cq[j];
            m_age[cq[j]] = 0;
        end
        if (n > 0 && !mode) m_ptr = (cq[n-1] + 1) % int'(NUM_REQ);
        m_hold = nh;
        m_own  = no;
        m_tout = nt;
        model_outputs();
    endtask

    task automatic tick();
        model_step();
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETN = 1'b0;
        req  = '0;
        rel  = '0;
        mode = 1'b0;
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b1;
        #2;
        ARESETN = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({grant, grant_res, res_busy, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_initial got g=%b r=%b b=%b t=%b exp all zero", grant, grant_res, res_busy, timeout);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        req = '1;
        tick();
        tick();
        checks++;
        if ({grant, grant_res, res_busy, timeout} !== {e_grant, e_gres, e_busy, e_tout}) begin
            errors++;
            $display("FAIL reset_pre cyc=%0d got g=%b r=%b b=%b t=%b exp g=%b r=%b b=%b t=%b",
                     cyc, grant, grant_res, res_busy, timeout, e_grant, e_gres, e_busy, e_tout);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({grant, grant_res, res_busy, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_midrun got g=%b r=%b b=%b t=%b exp all zero", grant, grant_res, res_busy, timeout);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001 || grant_res[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got g=%b r0=%b exp g=0001 r0=0", grant, grant_res[0]);
        end
    endtask

    task automatic test_round_robin();
        int cnt [NUM_REQ];
        do_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) cnt[i] = 0;
        mode = 1'b0;
        req  = '1;
        for (int c = 0; c < 32; c++) begin
            rel = e_grant;
            tick();
            checks++;
            if ({grant, grant_res, res_busy, timeout} !== {e_grant, e_gres, e_busy, e_tout}) begin
                errors++;
                $display("FAIL rr_step cyc=%0d got g=%b r=%b b=%b t=%b exp g=%b r=%b b=%b t=%b",
                         cyc, grant, grant_res, res_busy, timeout, e_grant, e_gres, e_busy, e_tout);
            end
            for (int i = 0; i < int'(NUM_REQ); i++) if (grant[i]) cnt[i]++;
        end
        rel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            checks++;
            if (cnt[i] !== 8) begin
                errors++;
                $display("FAIL rr_fairness req=%0d got %0d grants exp 8", i, cnt[i]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        int cnt [NUM_REQ];
        int exp_cnt [NUM_REQ];
        exp_cnt = '{16, 16, 0, 0};
        do_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) cnt[i] = 0;
        mode = 1'b1;
        req  = '1;
        for (int c = 0; c < 32; c++) begin
            rel = e_grant;
            tick();
            checks++;
            if ({grant, grant_res, res_busy, timeout} !== {e_grant, e_gres, e_busy, e_tout}) begin
                errors++;
                $display("FAIL fp_step cyc=%0d got g=%b r=%b b=%b t=%b exp g=%b r=%b b=%b t=%b",
                         cyc, grant, grant_res, res_busy, timeout, e_grant, e_gres, e_busy, e_tout);
            end
            for (int i = 0; i < int'(NUM_REQ); i++) if (grant[i]) cnt[i]++;
        end
        rel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            checks++;
            if (cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL fp_count req=%0d got %0d grants exp %0d", i, cnt[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_reuse();
        do_reset();
        mode = 1'b0;
        req  = 4'b0011;
        tick();
        req = 4'b0111;
        tick();
        tick();
        checks++;
        if ({grant, grant_res, res_busy, timeout} !== {e_grant, e_gres, e_busy, e_tout}) begin
            errors++;
            $display("FAIL reuse_full cyc=%0d got g=%b r=%b b=%b t=%b exp g=%b r=%b b=%b t=%b",
                     cyc, grant, grant_res, res_busy, timeout, e_grant, e_gres, e_busy, e_tout);
        end
        rel = 4'b0001;
        tick();
        rel = '0;
        checks++;
        if (grant !== 4'b0010 || res_busy !== 2'b10) begin
            errors++;
            $display("FAIL reuse_release got g=%b b=%b exp g=0010 b=10", grant, res_busy);
        end
        tick();
        checks++;
        if (grant[2] !== 1'b1 || grant_res[2] !== 1'b0 || res_busy !== 2'b11) begin
            errors++;
            $display("FAIL reuse_regrant got g=%b r=%b b=%b exp g[2]=1 r[2]=0 b=11", grant, grant_res, res_busy);
        end
        checks++;
        if ({grant, grant_res, res_busy, timeout} !== {e_grant, e_gres, e_busy, e_tout}) begin
            errors++;
            $display("FAIL reuse_model cyc=%0d got g=%b r=%b b=%b t=%b exp g=%b r=%b b=%b t=%b",
                     cyc, grant, grant_res, res_busy, timeout, e_grant, e_gres, e_busy, e_tout);
        end
    endtask

    task automatic test_drop_spurious();
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_res[1] !== 1'b0 || res_busy !== 2'b01) begin
            errors++;
            $display("FAIL drop_grant got g=%b r=%b b=%b exp g=0010 r[1]=0 b=01", grant, grant_res, res_busy);
        end
        rel = 4'b1000;
        tick();
        rel = '0;
        checks++;
        if (grant !== 4'b0010 || res_busy !== 2'b01 || grant_res !== 4'b0000) begin
            errors++;
            $display("FAIL spurious_rel got g=%b r=%b b=%b exp g=0010 r=0000 b=01", grant, grant_res, res_busy);
        end
        req = '0;
        tick();
        checks++;
        if (grant !== 4'b0000 || res_busy !== 2'b00) begin
            errors++;
            $display("FAIL drop_free got g=%b b=%b exp g=0000 b=00", grant, res_busy);
        end
    endtask

`ifdef HOLD_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        tick();
        req = 4'b0111;
        for (int c = 1; c <= int'(MAX_HOLD); c++) begin
            tick();
            checks++;
            if ({grant, grant_res, res_busy, timeout} !== {e_grant, e_gres, e_busy, e_tout}) begin
                errors++;
                $display("FAIL to_hold cyc=%0d got g=%b r=%b b=%b t=%b exp g=%b r=%b b=%b t=%b",
                         cyc, grant, grant_res, res_busy, timeout, e_grant, e_gres, e_busy, e_tout);
            end
        end
        tick();
        checks++;
        if (timeout !== 4'b0011 || grant !== 4'b0000 || res_busy !== 2'b00) begin
            errors++;
            $display("FAIL to_revoke got t=%b g=%b b=%b exp t=0011 g=0000 b=00", timeout, grant, res_busy);
        end
        tick();
        checks++;
        if (timeout !== 4'b0000 || grant !== 4'b0100 || grant_res[2] !== 1'b0) begin
            errors++;
            $display("FAIL to_waiter got t=%b g=%b r=%b exp t=0000 g=0100 r[2]=0", timeout, grant, grant_res);
        end
        req = '0;
        tick();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = NUM_REQ'($urandom | $urandom);
            rel = NUM_REQ'($urandom & $urandom & $urandom);
            if ($urandom_range(15) == 0) mode = ~mode;
            tick();
            checks++;
            if ({grant, grant_res, res_busy, timeout} !== {e_grant, e_gres, e_busy, e_tout}) begin
                errors++;
                $display("FAIL rand_step cyc=%0d got g=%b r=%b b=%b t=%b exp g=%b r=%b b=%b t=%b",
                         cyc, grant, grant_res, res_busy, timeout, e_grant, e_gres, e_busy, e_tout);
            end
        end
        req = '0;
        rel = '0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        req     = '0;
        rel     = '0;
        mode    = 1'b0;
        ARESETN = 1'b1;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_reuse();
        test_drop_spurious();
`ifdef HOLD_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nxm_rr_arb.md
Name: nxm_rr_arb

Overview:
Parametrised successor to the 2x2 arbiter. It shares NUM_RES identical resources among NUM_REQ requesters. It grants up to NUM_RES requesters at once, and each grant carries a resource index. Arbitration order is selectable at run time: round-robin or fixed-priority. It sits between master-side request logic and a shared pool of slave ports or buffers.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
NUM_RES, 2, number of shared resources (1..NUM_REQ)
RES_W, $clog2(NUM_RES) min 1, width of a resource index
MAX_HOLD, 16, grant hold limit in cycles (used only with HOLD_TIMEOUT_EN)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester
rel  in  NUM_REQ  release pulse per requester, valid only while granted
mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
grant  out  NUM_REQ  registered grant per requester
grant_res  out  NUM_REQ*RES_W  resource index held by requester i, in slice i
res_busy  out  NUM_RES  registered per-resource occupancy
timeout  out  NUM_REQ  one-cycle revoke pulse (HOLD_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async assert, sync release): grant=0, grant_res=0, res_busy=0, timeout=0, round-robin pointer=0, all owner tables cleared.
- Per-requester state:
  - IDLE: no grant held.
  - GRANTED: holding a resource.
  - Transitions: IDLE->GRANTED when allocated; GRANTED->IDLE on rel[i]=1, on req[i]=0, or on timeout.
- Latency:
  - req[i] rising at cycle t with a free resource gives grant[i]=1 at t+1 at the earliest.
  - A release sampled at t gives grant[i]=0 and the resource's res_busy=0 at t+1.
  - A freed resource is allocatable at t+1, so its new grant is visible at t+2. There is no same-cycle reuse.
- Allocation each cycle:
  - Candidates are requesters in IDLE with req=1. Free resources are those with res_busy=0.
  - Pair candidates in priority order with free resources in ascending index order. The grant count is min(#candidates, #free).
  - Round-robin: priority starts at the pointer and wraps modulo NUM_REQ. After any grant, the pointer becomes (last granted index + 1) mod NUM_REQ. With no grant, the pointer is held.
  - Fixed priority: lowest index first. The pointer is not updated.
- grant_res slice i is stable for the whole time grant[i]=1. It is 0 when grant[i]=0.
- A resource never has two owners. A requester never holds two resources.
- rel[i] while IDLE is ignored. req[i] held high after a release yields a new grant, subject to arbitration, no earlier than t+2.
- A mode change takes effect on the next allocation. Existing grants are untouched.
- Reset asserted mid-operation clears everything immediately. No rel is needed afterwards.
- All outputs are registered. There are no combinational paths from input to output.

Optional Feature:
HOLD_TIMEOUT_EN
- Defined:
  - Each granted requester has a hold counter, cleared on grant.
  - When the counter reaches MAX_HOLD with the grant still held, the grant is revoked on the next edge. timeout[i] pulses for one cycle with grant[i] falling, and the resource frees.
  - The revoked requester is skipped for one allocation cycle even if req stays high.
- Undefined: no counters are built, timeout is constant 0, and grants are held indefinitely.

Test Plan:
1. Reset check: ARESETN=0 mid-run with grants active -> grant, res_busy and timeout go to 0 immediately; after release, req=4'b0001 -> grant=4'b0001 and grant_res[0]=0 one cycle later.
2. Round-robin fairness: NUM_REQ=4, NUM_RES=2, mode=0, all req high, each grantee releases one cycle after grant -> grants rotate {0,1},{2,3},{0,1}..., each requester served equally over 8 rounds.
3. Fixed priority: mode=1, req=4'b1111, releases as in test 2 -> requesters 0 and 1 always re-win; 2 and 3 are never granted.
4. Saturation and reuse: 2 resources busy, req[2]=1, rel[0] at cycle t -> grant[0]=0 at t+1, grant[2]=1 with grant_res[2]=0 at t+2.
5. Release-by-drop and spurious release: req[1] drops while granted -> resource frees next cycle; rel[3] while IDLE -> no state change.
6. Timeout (HOLD_TIMEOUT_EN, MAX_HOLD=16): requester holds its grant with no release -> timeout pulse and grant drop 17 cycles after grant; a competing waiter is granted the following cycle.
